// File: rtl/clock_gen_multi_if.sv
// rtl/clock_gen_multi_if.sv - configuration request bus for clock_gen_multi
interface clock_gen_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_half;
  logic [CNT_W:0]   cfg_phase;
  logic             cfg_inv;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_half, cfg_phase, cfg_inv,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_half, cfg_phase, cfg_inv,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/clock_gen_multi.sv
// rtl/clock_gen_multi.sv - multi-channel programmable clock generator with glitch-free reconfiguration
module clock_gen_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              restart,
  clock_gen_multi_if.slave  cfg,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW   = CNT_W + 1;

  // Active per-channel settings and counters
  logic [CNT_W-1:0] h_q       [NUM_CH];
  logic [CNT_W-1:0] h_d       [NUM_CH];
  logic [CW-1:0]    phase_q   [NUM_CH];
  logic [CW-1:0]    phase_d   [NUM_CH];
  logic [CW-1:0]    cnt_q     [NUM_CH];
  logic [CW-1:0]    cnt_d     [NUM_CH];
  logic [CW-1:0]    wrap_at   [NUM_CH];
  logic [NUM_CH-1:0] inv_q, inv_d;

  // Pending (staged) settings, applied at wrap or restart
  logic [CNT_W-1:0] p_h_q     [NUM_CH];
  logic [CNT_W-1:0] p_h_d     [NUM_CH];
  logic [CW-1:0]    p_phase_q [NUM_CH];
  logic [CW-1:0]    p_phase_d [NUM_CH];
  logic [NUM_CH-1:0] p_inv_q, p_inv_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] seen_q, seen_d;

  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic              locked_q, locked_d;
  logic              err_q;

  logic [NUM_CH-1:0] ch_hit;
  logic              in_range;
  logic              pend_sel;
  logic              bad_val;
  logic              accept;
  logic              reject;
  logic              take;

  // Decode the request: target channel, busy state and value legality
  always_comb begin
    ch_hit   = '0;
    pend_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit[i] = (cfg.cfg_ch == CH_W'(i));
      if (ch_hit[i]) pend_sel = pend_q[i];
    end
    in_range = |ch_hit;
    bad_val  = (cfg.cfg_half == '0) || (cfg.cfg_phase >= {cfg.cfg_half, 1'b0});
    accept   = cfg.cfg_valid && !(in_range && pend_sel);
    reject   = accept && (!in_range || bad_val);
    take     = accept && !reject;
  end

  assign cfg.cfg_ready = !(in_range && pend_sel);
  assign cfg.cfg_err   = err_q;
  assign clk_out       = clk_q;
  assign tick          = tick_q;
  assign locked        = locked_q;

  // Next state per channel: restart beats wrap beats count; outputs track next counts
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      h_d[i]       = h_q[i];
      phase_d[i]   = phase_q[i];
      inv_d[i]     = inv_q[i];
      cnt_d[i]     = cnt_q[i];
      p_h_d[i]     = p_h_q[i];
      p_phase_d[i] = p_phase_q[i];
      p_inv_d[i]   = p_inv_q[i];
      pend_d[i]    = pend_q[i];
      seen_d[i]    = seen_q[i];
      wrap_at[i]   = {h_q[i], 1'b0} - CW'(1);

      if (restart) begin
        if (pend_q[i]) begin
          h_d[i]     = p_h_q[i];
          phase_d[i] = p_phase_q[i];
          inv_d[i]   = p_inv_q[i];
          pend_d[i]  = 1'b0;
          cnt_d[i]   = p_phase_q[i];
        end else begin
          cnt_d[i]   = phase_q[i];
        end
      end else if (run) begin
        if (cnt_q[i] == wrap_at[i]) begin
          cnt_d[i]  = '0;
          seen_d[i] = 1'b1;
          if (pend_q[i]) begin
            h_d[i]     = p_h_q[i];
            phase_d[i] = p_phase_q[i];
            inv_d[i]   = p_inv_q[i];
            pend_d[i]  = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end

      // A request can only land on an idle pending slot, so it never races an apply
      if (take && ch_hit[i]) begin
        p_h_d[i]     = cfg.cfg_half;
        p_phase_d[i] = cfg.cfg_phase;
        p_inv_d[i]   = cfg.cfg_inv;
        pend_d[i]    = 1'b1;
      end

      if (restart || take) seen_d[i] = 1'b0;

      clk_d[i]  = (cnt_d[i] >= {1'b0, h_d[i]}) ^ inv_d[i];
      tick_d[i] = run && clk_d[i] && !clk_q[i];
    end
    locked_d = &seen_d;
  end

  // State registers with asynchronous reset to the default divide-by-2 setting
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        h_q[i]       <= CNT_W'(1);
        phase_q[i]   <= '0;
        cnt_q[i]     <= '0;
        p_h_q[i]     <= CNT_W'(1);
        p_phase_q[i] <= '0;
      end
      inv_q    <= '0;
      p_inv_q  <= '0;
      pend_q   <= '0;
      seen_q   <= '0;
      clk_q    <= '0;
      tick_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        h_q[i]       <= h_d[i];
        phase_q[i]   <= phase_d[i];
        cnt_q[i]     <= cnt_d[i];
        p_h_q[i]     <= p_h_d[i];
        p_phase_q[i] <= p_phase_d[i];
      end
      inv_q    <= inv_d;
      p_inv_q  <= p_inv_d;
      pend_q   <= pend_d;
      seen_q   <= seen_d;
      clk_q    <= clk_d;
      tick_q   <= tick_d;
      locked_q <= locked_d;
      err_q    <= reject;
    end
  end
endmodule

// File: tb/tb_clock_gen_multi.sv
// tb/tb_clock_gen_multi.sv - randomized bench for clock_gen_multi against a period-position model
module tb_clock_gen_multi;
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic run     = 1'b0;
  logic restart = 1'b0;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic              locked;

  clock_gen_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_bus ();

  clock_gen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .restart (restart),
    .cfg     (cfg_bus.slave),
    .clk_out (clk_out),
    .tick    (tick),
    .locked  (locked)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: each channel is a position within its 2H-cycle period
  int m_h     [NUM_CH];
  int m_phase [NUM_CH];
  int m_inv   [NUM_CH];
  int m_pos   [NUM_CH];
  int m_pend  [NUM_CH];
  int m_ph    [NUM_CH];
  int m_pphase[NUM_CH];
  int m_pinv  [NUM_CH];
  int m_seen  [NUM_CH];
  int m_clk   [NUM_CH];
  int m_tick  [NUM_CH];
  int m_locked;
  int m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [31:0] vec(input int a [NUM_CH]);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) v[i] = (a[i] != 0);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_h[i] = 1; m_phase[i] = 0; m_inv[i] = 0; m_pos[i] = 0;
      m_pend[i] = 0; m_ph[i] = 1; m_pphase[i] = 0; m_pinv[i] = 0;
      m_seen[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
    end
    m_locked = 0;
    m_err    = 0;
  endtask

  function automatic int model_ready(input int ch);
    if (ch < NUM_CH && m_pend[ch] != 0) return 0;
    return 1;
  endfunction

  task automatic apply_pending(input int i);
    m_h[i] = m_ph[i]; m_phase[i] = m_pphase[i]; m_inv[i] = m_pinv[i]; m_pend[i] = 0;
  endtask

  task automatic model_step(input int r, input int rs, input int v, input int ch,
                            input int half, input int phase, input int inv);
    int acc, bad, take, all;
    acc  = v && model_ready(ch);
    bad  = (ch >= NUM_CH) || (half == 0) || (phase >= 2 * half);
    take = acc && !bad;
    m_err = acc && bad;
    for (int i = 0; i < NUM_CH; i++) begin
      int prev;
      prev = m_clk[i];
      if (rs != 0) begin
        if (m_pend[i] != 0) apply_pending(i);
        m_pos[i] = m_phase[i];
      end else if (r != 0) begin
        if (m_pos[i] == 2 * m_h[i] - 1) begin
          m_pos[i]  = 0;
          m_seen[i] = 1;
          if (m_pend[i] != 0) apply_pending(i);
        end else begin
          m_pos[i] = m_pos[i] + 1;
        end
      end
      if (take && ch == i) begin
        m_ph[i] = half; m_pphase[i] = phase; m_pinv[i] = inv; m_pend[i] = 1;
      end
      m_clk[i]  = ((m_pos[i] >= m_h[i]) ? 1 : 0) ^ m_inv[i];
      m_tick[i] = (r != 0) && m_clk[i] == 1 && prev == 0;
    end
    if (rs != 0 || take) for (int i = 0; i < NUM_CH; i++) m_seen[i] = 0;
    all = 1;
    for (int i = 0; i < NUM_CH; i++) if (m_seen[i] == 0) all = 0;
    m_locked = all;
  endtask

  task automatic check_outputs();
    check("clk_out", 32'(clk_out), vec(m_clk));
    check("tick",    32'(tick),    vec(m_tick));
    check("locked",  32'(locked),  32'(m_locked));
    check("cfg_err", 32'(cfg_bus.cfg_err), 32'(m_err));
  endtask

  // One clock: drive just after a falling edge, check ready, step model, check at next falling edge
  task automatic cycle(input int r, input int rs, input int v, input int ch,
                       input int half, input int phase, input int inv);
    run               = r[0];
    restart           = rs[0];
    cfg_bus.cfg_valid = v[0];
    cfg_bus.cfg_ch    = CH_W'(ch);
    cfg_bus.cfg_half  = CNT_W'(half);
    cfg_bus.cfg_phase = (CNT_W + 1)'(phase);
    cfg_bus.cfg_inv   = inv[0];
    #1;
    check("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(model_ready(ch)));
    model_step(r, rs, v, ch, half, phase, inv);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle(input int n, input int ch);
    for (int k = 0; k < n; k++) cycle(1, 0, 0, ch, 1, 0, 0);
  endtask

  task automatic do_reset();
    cfg_bus.cfg_valid = 1'b0;
    restart           = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_tick",    32'(tick),    32'd0);
    check("rst_locked",  32'(locked),  32'd0);
    check("rst_cfg_err", 32'(cfg_bus.cfg_err), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int waited;
    model_reset();
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_ch    = '0;
    cfg_bus.cfg_half  = '0;
    cfg_bus.cfg_phase = '0;
    cfg_bus.cfg_inv   = 1'b0;
    repeat (2) @(negedge clock);
    check_outputs();
    reset = 1'b0;

    // Defaults: every channel divides by 2
    idle(6, 0);

    // ch1 to H=2; ready stays low until its wrap
    cycle(1, 0, 1, 1, 2, 0, 0);
    idle(12, 1);

    // ch2 to H=3 phase=2 inverted, then restart applies it
    cycle(1, 0, 1, 2, 3, 2, 1);
    cycle(1, 1, 0, 2, 1, 0, 0);
    idle(10, 2);

    // Rejected requests
    cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 3, 6, 0);
    cycle(1, 0, 1, 3, 2, 0, 0);
    idle(2, 0);

    // Second request to a busy channel is held off
    cycle(1, 0, 1, 0, 4, 1, 0);
    cycle(1, 0, 1, 0, 2, 0, 1);
    idle(10, 0);

    // Request landing on the wrap cycle of ch1
    waited = 0;
    while (!(m_pos[1] == 2 * m_h[1] - 1 && m_pend[1] == 0) && waited < 40) begin
      idle(1, 1);
      waited++;
    end
    check("wrap_align_reached", 32'(waited < 40), 32'd1);
    cycle(1, 0, 1, 1, 1, 1, 1);
    idle(12, 1);

    // Reset in mid-period with a pending request
    cycle(1, 0, 1, 2, 5, 3, 0);
    idle(1, 2);
    do_reset();
    idle(4, 2);

    // Randomized traffic, including run stalls, restarts and occasional resets
    for (int n = 0; n < 3000; n++) begin
      int half;
      half = $urandom_range(0, 4);
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle(($urandom_range(0, 9) != 0) ? 1 : 0,
            ($urandom_range(0, 39) == 0) ? 1 : 0,
            ($urandom_range(0, 2) == 0) ? 1 : 0,
            $urandom_range(0, 3),
            half,
            $urandom_range(0, 2 * half + 1),
            $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
